// File: rtl/spi_buf_slave_if.sv
// spi_buf_slave_if: SPI pins plus register-bank access signals of the buffer-side slave
interface spi_buf_slave_if;
    logic       SCK;
    logic       CS_n;
    logic       MOSI;
    logic       MISO_buf;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic       rd_stb;
    logic [7:0] rd_data;
    logic       busy;
    logic       frame_err;
    modport slave (
        input  SCK, CS_n, MOSI, rd_data,
        output MISO_buf, miso_oe, reg_addr, wr_data, wr_stb, rd_stb, busy, frame_err
    );
    modport master (
        output SCK, CS_n, MOSI, rd_data,
        input  MISO_buf, miso_oe, reg_addr, wr_data, wr_stb, rd_stb, busy, frame_err
    );
endinterface

// File: rtl/spi_buf_slave.sv
// spi_buf_slave: oversampled SPI mode-0 slave turning cmd/addr/data frames into register strobes
module spi_buf_slave #(
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    spi_buf_slave_if.slave bus
);
    typedef enum logic [1:0] {WAIT_HI, IDLE, CMD, DATA} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, flush;
    logic                   sck_q, is_read, skip, rd_pend, wr_pend, inc_pend;
    logic [2:0]             cnt;
    logic [7:0]             rx_sr, tx_sr, rx_nxt;
    logic                   sck, cs_n, mosi, rise, fall, last;

    assign sck      = sck_sync[SYNC_STAGES-1];
    assign cs_n     = cs_sync[SYNC_STAGES-1];
    assign mosi     = mosi_sync[SYNC_STAGES-1];
    assign rise     = sck & ~sck_q;
    assign fall     = ~sck & sck_q;
    assign last     = rise && cnt == 3'd7;
    assign rx_nxt   = {rx_sr[6:0], mosi};
    assign bus.busy = state == CMD || state == DATA;

    // Synchronizers; flush marks when reset values have been pushed out of the CS_n chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            flush     <= '0;
            sck_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
            sck_q     <= sck;
        end
    end

    // Frame FSM: bit counting, shift registers, strobes and MISO drive
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_HI;
            cnt           <= 3'd0;
            rx_sr         <= 8'd0;
            tx_sr         <= 8'd0;
            is_read       <= 1'b0;
            skip          <= 1'b0;
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            inc_pend      <= 1'b0;
            bus.reg_addr  <= 7'd0;
            bus.wr_data   <= 8'd0;
            bus.wr_stb    <= 1'b0;
            bus.rd_stb    <= 1'b0;
            bus.miso_oe   <= 1'b0;
            bus.MISO_buf  <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.rd_stb    <= rd_pend;
            bus.wr_stb    <= wr_pend;
            inc_pend      <= wr_pend;
            bus.MISO_buf  <= bus.miso_oe & tx_sr[7];
            if (wr_pend)
                bus.wr_data <= rx_sr;
            if (inc_pend)
                bus.reg_addr <= bus.reg_addr + 7'd1;
            if (state != WAIT_HI && cs_n) begin
                bus.frame_err <= (state == CMD || state == DATA) && cnt != 3'd0 && !last;
                state         <= IDLE;
                cnt           <= 3'd0;
                skip          <= 1'b0;
                bus.miso_oe   <= 1'b0;
                bus.MISO_buf  <= 1'b0;
            end else begin
                case (state)
                    WAIT_HI: state <= (flush[SYNC_STAGES-1] && cs_n) ? IDLE : WAIT_HI;
                    IDLE: begin
                        state <= CMD;
                        cnt   <= 3'd0;
                    end
                    CMD: if (rise) begin
                        rx_sr <= rx_nxt;
                        cnt   <= cnt + 3'd1;
                        if (last) begin
                            is_read      <= rx_nxt[7];
                            rd_pend      <= rx_nxt[7];
                            bus.reg_addr <= rx_nxt[6:0];
                            skip         <= 1'b1;
                            state        <= DATA;
                        end
                    end
                    DATA: begin
                        if (rise) begin
                            cnt <= cnt + 3'd1;
                            if (!is_read)
                                rx_sr <= rx_nxt;
                            if (last) begin
                                skip    <= 1'b1;
                                rd_pend <= is_read;
                                wr_pend <= !is_read;
                                if (is_read)
                                    bus.reg_addr <= bus.reg_addr + 7'd1;
                            end
                        end
                        if (fall) begin
                            skip <= 1'b0;
                            if (!skip)
                                tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                        if (bus.rd_stb) begin
                            tx_sr       <= bus.rd_data;
                            bus.miso_oe <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_buf_slave.sv
// tb_spi_buf_slave: table-driven SPI frames with a strobe scoreboard against a register bank model
module tb_spi_buf_slave;
    localparam int H = 8;
    localparam int NV = 9;

    typedef struct {
        int         nb;
        logic [7:0] b0, b1, b2;
        int         bits;
        bit         race;
        int         err;
    } vec_t;

    typedef struct {
        logic       is_wr;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         err_cnt = 0;
    int         viol = 0;
    int         miso_bad = 0;
    bit         watch = 1'b0;
    ev_t        exp_q[$];
    logic [7:0] bank[128];
    logic [7:0] model_mem[128];
    logic [7:0] fb[3];
    logic [7:0] rxb[3];
    vec_t       vt[NV];

    spi_buf_slave_if bus ();

    spi_buf_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.rd_data = bank[bus.reg_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe scoreboard, bank writes, and continuous output-invariant watching
    always @(negedge clk) begin
        if (bus.wr_stb || bus.rd_stb) begin
            chk("stb_exclusive", {31'd0, bus.wr_stb & bus.rd_stb}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got wr=%0b rd=%0b addr=%0h, required none", bus.wr_stb, bus.rd_stb, bus.reg_addr);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("strobe", {16'd0, bus.wr_stb, bus.reg_addr, bus.wr_stb ? bus.wr_data : 8'h00},
                    {16'd0, e.is_wr, e.addr, e.data});
            end
            if (bus.wr_stb)
                bank[bus.reg_addr] = bus.wr_data;
        end
        if (bus.frame_err)
            err_cnt++;
        if (!bus.miso_oe && bus.MISO_buf)
            miso_bad++;
        if (watch && (bus.busy || bus.miso_oe || bus.MISO_buf))
            viol++;
    end

    // Mode-0 master: bits of the last byte limited to 'bits'; 'race' raises CS_n with the final rise
    task automatic xfer(input int nb, input int bits, input bit race);
        bus.CS_n = 1'b0;
        for (int i = 0; i < nb; i++) begin
            int nbits;
            nbits = (i == nb - 1) ? bits : 8;
            for (int j = 7; j >= 8 - nbits; j--) begin
                bus.MOSI = fb[i][j];
                clks(H);
                rxb[i][j] = bus.MISO_buf;
                bus.SCK = 1'b1;
                if (race && i == nb - 1 && j == 8 - nbits)
                    bus.CS_n = 1'b1;
                clks(H);
                bus.SCK = 1'b0;
            end
        end
        clks(H);
        bus.CS_n = 1'b1;
        clks(4 * H);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.SCK  = 1'b0;
        bus.CS_n = 1'b1;
        bus.MOSI = 1'b0;
        for (int i = 0; i < 128; i++) begin
            model_mem[i] = 8'($urandom);
            bank[i] = model_mem[i];
        end
        model_mem[7'h10] = 8'h12;
        model_mem[7'h11] = 8'h34;
        bank[7'h10] = 8'h12;
        bank[7'h11] = 8'h34;
        vt[0] = '{3, 8'h05, 8'hA5, 8'h3C, 8, 1'b0, 0};
        vt[1] = '{3, 8'h90, 8'h00, 8'h00, 8, 1'b0, 0};
        vt[2] = '{3, 8'h7F, 8'h01, 8'h02, 8, 1'b0, 0};
        vt[3] = '{2, 8'h20, 8'hB7, 8'h00, 3, 1'b0, 1};
        vt[4] = '{2, 8'h21, 8'h5A, 8'h00, 8, 1'b0, 0};
        vt[5] = '{3, 8'hFF, 8'h00, 8'h00, 8, 1'b0, 0};
        vt[6] = '{2, 8'h30, 8'hC3, 8'h00, 8, 1'b1, 0};
        vt[7] = '{1, 8'h85, 8'h00, 8'h00, 8, 1'b0, 0};
        vt[8] = '{1, 8'h44, 8'h00, 8'h00, 5, 1'b0, 1};

        clks(4);
        chk("reset_outputs", {15'd0, bus.MISO_buf, bus.miso_oe, bus.reg_addr, bus.wr_data, bus.wr_stb, bus.rd_stb, bus.busy, bus.frame_err},
            32'd0);
        rst = 1'b0;
        clks(2);
        chk("post_reset_outputs", {15'd0, bus.MISO_buf, bus.miso_oe, bus.reg_addr, bus.wr_data, bus.wr_stb, bus.rd_stb, bus.busy, bus.frame_err},
            32'd0);
        clks(4);

        for (int v = 0; v < NV; v++) begin
            logic       rw;
            logic [6:0] a;
            int         nd, e0;
            fb[0] = vt[v].b0;
            fb[1] = vt[v].b1;
            fb[2] = vt[v].b2;
            rw = fb[0][7];
            a = fb[0][6:0];
            nd = vt[v].nb - 1 - ((vt[v].bits < 8 || vt[v].race) ? 1 : 0);
            if (vt[v].nb == 1 && vt[v].bits < 8)
                rw = 1'b0;
            if (rw) begin
                for (int i = 0; i <= nd; i++)
                    exp_q.push_back('{1'b0, a + 7'(i), 8'h00});
            end else begin
                for (int i = 0; i < nd; i++) begin
                    exp_q.push_back('{1'b1, a + 7'(i), fb[i+1]});
                    model_mem[a + 7'(i)] = fb[i+1];
                end
            end
            e0 = err_cnt;
            xfer(vt[v].nb, vt[v].bits, vt[v].race);
            chk($sformatf("v%0d_pending_strobes", v), exp_q.size(), 0);
            exp_q.delete();
            chk($sformatf("v%0d_frame_err", v), err_cnt - e0, vt[v].err);
            chk($sformatf("v%0d_busy_oe_after", v), {30'd0, bus.busy, bus.miso_oe}, 32'd0);
            if (rw)
                for (int i = 0; i < nd; i++)
                    chk($sformatf("v%0d_rx_byte%0d", v, i), {24'd0, rxb[i+1]}, {24'd0, model_mem[a + 7'(i)]});
        end

        // Reset asserted in the middle of a frame: the remainder must be ignored
        begin
            int e0;
            e0 = err_cnt;
            bus.CS_n = 1'b0;
            for (int k = 0; k < 12; k++) begin
                bus.MOSI = 1'($urandom);
                clks(H);
                bus.SCK = 1'b1;
                if (k == 4) begin
                    rst = 1'b1;
                    clks(1);
                    watch = 1'b1;
                    clks(H - 1);
                end else begin
                    clks(H);
                end
                bus.SCK = 1'b0;
                if (k == 5)
                    rst = 1'b0;
            end
            clks(H);
            watch = 1'b0;
            chk("rst_midframe_quiet", viol, 0);
            bus.CS_n = 1'b1;
            clks(4 * H);
            chk("rst_midframe_no_err", err_cnt - e0, 0);
            fb[0] = 8'h01;
            fb[1] = 8'hFF;
            exp_q.push_back('{1'b1, 7'h01, 8'hFF});
            xfer(2, 8, 1'b0);
            chk("after_rst_write", exp_q.size(), 0);
            exp_q.delete();
        end

        // Idle bus: SCK and MOSI toggling with CS_n high
        viol = 0;
        watch = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.MOSI = 1'($urandom);
            clks(H);
            bus.SCK = 1'b1;
            clks(H);
            bus.SCK = 1'b0;
        end
        watch = 1'b0;
        chk("idle_bus_quiet", viol, 0);
        chk("miso_gated_by_oe", miso_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_buf_slave.md
# spi_buf_slave

SPI mode-0 slave that answers the MCU on the buffer side of the shared MISO line: it decodes command/address/data frames from the MCU and drives `MISO_buf`, which the external MISO selector routes to the MCU when the Ethernet chip is not selected. SCK, CS_n and MOSI are oversampled in the FPGA system clock. Decoded accesses are presented as single-cycle read/write strobes to a local register bank.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on SCK/CS_n/MOSI (2 or 3).

Ports:
- `clk`  in  1  system clock; must be ≥ 16× SCK frequency.
- `rst`  in  1  synchronous reset, active-high.
- `SCK`  in  1  SPI clock from MCU, idle low, asynchronous.
- `CS_n`  in  1  slave select from MCU, active low, asynchronous.
- `MOSI`  in  1  MCU data in, asynchronous.
- `MISO_buf`  out  1  slave data out, MSB first.
- `miso_oe`  out  1  high while a read data phase is active.
- `reg_addr`  out  7  current register address.
- `wr_data`  out  8  write byte; valid with `wr_stb`.
- `wr_stb`  out  1  one-cycle write strobe.
- `rd_stb`  out  1  one-cycle read request for `reg_addr`.
- `rd_data`  in  8  register read value; sampled 1 cycle after `rd_stb`.
- `busy`  out  1  frame in progress.
- `frame_err`  out  1  one-cycle pulse on a frame aborted mid-byte.

## Operation
- SCK, CS_n and MOSI each pass through `SYNC_STAGES` flops. Synchronizer reset value is 1 for CS_n and 0 for SCK/MOSI. Rise and fall events come from the synchronized SCK and its previous value.
- Frame format:
  - Byte 0 is the command: bit7 = R/W (1 = read), bits6:0 = start address.
  - Bytes 1..N are data. The address auto-increments after each data byte and wraps 127 → 0.
- States:
  - WAIT_HI: entered on reset. Moves to IDLE once synchronized CS_n is high, so a frame that is in progress at reset is ignored.
  - IDLE: on synchronized CS_n low, go to CMD with bit counter = 0.
  - CMD: on each SCK rise, shift MOSI into `rx_sr` (LSB in) and increment the counter. On the 8th rise, latch R/W and `reg_addr`, clear the counter, and go to DATA. For a read, pulse `rd_stb` on the next cycle.
  - DATA, write: on the 8th rise, drive `wr_data` = `rx_sr`, pulse `wr_stb` for one cycle, then increment `reg_addr` on the following cycle.
  - DATA, read:
    - `tx_sr` loads `rd_data` one cycle after `rd_stb`.
    - `MISO_buf` = `tx_sr[7]`.
    - On each SCK fall, `tx_sr` shifts left, except the fall that follows a byte's 8th rise, which does not shift.
    - On a data byte's 8th rise, increment `reg_addr` and pulse `rd_stb` on the next cycle to prefetch the next byte.
    - MOSI is ignored.
  - Any state other than WAIT_HI: synchronized CS_n high returns the block to IDLE.
    - Partial bytes are discarded with no strobe.
    - `frame_err` pulses if the bit counter ≠ 0.
    - `miso_oe` and `MISO_buf` go to 0.
- `busy` = state is CMD or DATA.
- `MISO_buf` = 0 whenever `miso_oe` = 0.

## Timing
- Reset values:
  - All outputs 0; `reg_addr` = 0.
  - `tx_sr`, `rx_sr` and the bit counter = 0.
  - State = WAIT_HI.
- Write latency: `wr_stb` is asserted `SYNC_STAGES`+2 cycles after the 8th SCK rising edge at the pin.
- Read latency:
  - `rd_stb` is asserted `SYNC_STAGES`+2 cycles after the command's 8th rising edge.
  - `MISO_buf` is valid with the MSB 2 cycles after `rd_stb`.
  - With `SYNC_STAGES` = 2 this totals 6 cycles, inside the 8-cycle half-period at 16× oversampling, so the MSB is stable before the master's first data-byte rise.
- `miso_oe` rises in the same cycle as the first `tx_sr` load and falls 1 cycle after synchronized CS_n goes high.
- Simultaneous CS_n deassert and 8th SCK rise in the same synchronized cycle: CS_n wins; no strobe is issued and `frame_err` is not asserted.
- `wr_stb` and `rd_stb` are never asserted together. Minimum spacing between strobes is 8 SCK periods.

## Test plan
- Write burst: CMD 0x05, data 0xA5, 0x3C at SCK = clk/16 → `wr_stb` twice; (addr, data) = (0x05, 0xA5), then (0x06, 0x3C); `busy` falls after CS_n high.
- Read burst: CMD 0x90, bank returns 0x12 at addr 0x10 and 0x34 at 0x11 → MCU shifts in 0x12 then 0x34; `rd_stb` at addr 0x10, 0x11, 0x12 (the third is the prefetch).
- Wrap: write CMD 0x7F, data 0x01, 0x02 → writes go to addr 0x7F, then 0x00.
- Abort: CS_n high after 3 bits of a write data byte → no `wr_stb`; `frame_err` pulses once; the next frame decodes correctly.
- Reset mid-frame: assert `rst` while CS_n is low and SCK is toggling → no strobes and `MISO_buf` = 0 until CS_n goes high; the following frame CMD 0x01, data 0xFF yields `wr_stb` at (0x01, 0xFF).
- Idle bus: SCK toggling with CS_n high → no strobes; `miso_oe` = 0 and `busy` = 0 throughout.
